// File: rtl/adder_tree_operand_loader_pkg.sv
// adder_tree_pkg: shared defaults and bank state type for the adder-tree operand loader
package adder_tree_pkg;
  localparam int ADDER_WIDTH = 48;
  localparam int NUM_OPERANDS = 8;
  localparam int IDX_W = $clog2(NUM_OPERANDS);
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
endpackage

// File: rtl/adder_tree_operand_loader_if.sv
// adder_tree_operand_loader_if: operand word stream in, parallel batch out
interface adder_tree_operand_loader_if #(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int NUM_OPERANDS = adder_tree_pkg::NUM_OPERANDS,
  parameter int CNT_W = adder_tree_pkg::CNT_W
);
  logic in_valid;
  logic in_ready;
  logic [ADDER_WIDTH-1:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_operands;
  logic [CNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_operands, out_count
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_operands, out_count
  );
endinterface

// File: rtl/adder_tree_operand_loader_operand_bank.sv
// operand_bank: one ping-pong bank that fills slot by slot and zero-pads unused slots on close
module operand_bank
  import adder_tree_pkg::*;
#(
  parameter int W = ADDER_WIDTH,
  parameter int N = NUM_OPERANDS,
  parameter int CW = CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en_i,
  input  logic [W-1:0]   data_i,
  input  logic           last_i,
  input  logic           rd_en_i,
  output logic           close_o,
  output bank_state_t    state_o,
  output logic [N*W-1:0] operands_o,
  output logic [CW-1:0]  count_o
);
  localparam int IW = $clog2(N);
  bank_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] mem_q [N];
  // a FULL bank is never written and only a FULL bank is read, so wr_en_i and rd_en_i never coincide
  always_comb begin
    close_o = wr_en_i && (last_i || idx_q == IW'(N - 1));
    state_d = rd_en_i ? EMPTY : close_o ? FULL : wr_en_i ? FILLING : state_q;
    idx_d = (rd_en_i || close_o) ? '0 : wr_en_i ? idx_q + IW'(1) : idx_q;
    cnt_d = close_o ? CW'(idx_q) + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < N; i++)
        if (wr_en_i && IW'(i) == idx_q) mem_q[i] <= data_i;
        else if (close_o && IW'(i) > idx_q) mem_q[i] <= '0;
    end
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign operands_o[g*W +: W] = mem_q[g];
  end
  assign state_o = state_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/adder_tree_operand_loader.sv
// adder_tree_operand_loader: packs streamed operands into ping-pong batches for the adder tree
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int NUM_OPERANDS = adder_tree_pkg::NUM_OPERANDS,
  parameter int CNT_W = adder_tree_pkg::CNT_W
) (
  input logic clk,
  input logic reset,
  adder_tree_operand_loader_if.slave io
);
  bank_state_t st [2];
  logic [NUM_OPERANDS*ADDER_WIDTH-1:0] ops [2];
  logic [CNT_W-1:0] cnt [2];
  logic close [2];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic acc, xfer;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_bank #(.W(ADDER_WIDTH), .N(NUM_OPERANDS), .CW(CNT_W)) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (acc && wr_bank_q == 1'(b)),
      .data_i    (io.in_data),
      .last_i    (io.in_last),
      .rd_en_i   (xfer && rd_bank_q == 1'(b)),
      .close_o   (close[b]),
      .state_o   (st[b]),
      .operands_o(ops[b]),
      .count_o   (cnt[b])
    );
  end
  // ready looks only at registered bank state so a bank freed this cycle is writable next cycle
  assign io.in_ready = st[wr_bank_q] != FULL && !reset;
  assign io.out_valid = st[rd_bank_q] == FULL;
  assign io.out_operands = ops[rd_bank_q];
  assign io.out_count = cnt[rd_bank_q];
  always_comb begin
    acc = io.in_valid && io.in_ready;
    xfer = io.out_valid && io.out_ready;
    wr_bank_d = close[wr_bank_q] ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = xfer ? ~rd_bank_q : rd_bank_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// tb_adder_tree_operand_loader: directed table and sequence checks of the operand loader
module tb_adder_tree_operand_loader;
  localparam int W = 48;
  localparam int N = 8;
  typedef struct {
    int n;
    logic last;
    logic [W-1:0] w [N];
    logic [3:0] cnt;
    logic [W-1:0] exp [N];
  } vec_t;
  typedef struct {
    logic [3:0] cnt;
    logic [W-1:0] s [N];
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vec [5];
  rec_t q [$];
  rec_t mon_r;
  adder_tree_operand_loader_if bus ();
  adder_tree_operand_loader dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.out_valid && bus.out_ready) begin
      mon_r.cnt = bus.out_count;
      for (int j = 0; j < N; j++) mon_r.s[j] = bus.out_operands[j*W +: W];
      q.push_back(mon_r);
    end
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input logic l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    while (!bus.in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic check_batch(input string name, input logic [3:0] c, input logic [W-1:0] e [N]);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_count"}, 64'(bus.out_count), 64'(c));
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_slot%0d", name, j), 64'(bus.out_operands[j*W +: W]), 64'(e[j]));
  endtask
  task automatic wait_q(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 100) begin
      tick();
      t++;
    end
  endtask
  initial begin
    logic [W-1:0] e [N];
    int gaps;
    vec[0].n = 8; vec[0].last = 1'b0; vec[0].cnt = 4'd8;
    vec[0].w   = '{48'h100, 48'h101, 48'h102, 48'h103, 48'h104, 48'h105, 48'h106, 48'h107};
    vec[0].exp = '{48'h100, 48'h101, 48'h102, 48'h103, 48'h104, 48'h105, 48'h106, 48'h107};
    vec[1].n = 3; vec[1].last = 1'b1; vec[1].cnt = 4'd3;
    vec[1].w   = '{48'hA, 48'hB, 48'hC, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    vec[1].exp = '{48'hA, 48'hB, 48'hC, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    vec[2].n = 1; vec[2].last = 1'b1; vec[2].cnt = 4'd1;
    vec[2].w   = '{48'hFFFF_FFFF_FFFF, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    vec[2].exp = '{48'hFFFF_FFFF_FFFF, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    vec[3].n = 7; vec[3].last = 1'b1; vec[3].cnt = 4'd7;
    vec[3].w   = '{48'h301, 48'h302, 48'h303, 48'h304, 48'h305, 48'h306, 48'h307, 48'h0};
    vec[3].exp = '{48'h301, 48'h302, 48'h303, 48'h304, 48'h305, 48'h306, 48'h307, 48'h0};
    vec[4].n = 8; vec[4].last = 1'b1; vec[4].cnt = 4'd8;
    vec[4].w   = '{48'h401, 48'h402, 48'h403, 48'h404, 48'h405, 48'h406, 48'h407, 48'h408};
    vec[4].exp = '{48'h401, 48'h402, 48'h403, 48'h404, 48'h405, 48'h406, 48'h407, 48'h408};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_operands_zero", 64'(bus.out_operands == '0), 64'd1);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    // full batch 1..8 streamed with the consumer always ready
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.in_data = W'(i + 1);
      chk($sformatf("t1_in_ready%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    e = '{48'd1, 48'd2, 48'd3, 48'd4, 48'd5, 48'd6, 48'd7, 48'd8};
    check_batch("t1", 4'd8, e);
    tick();
    chk("t1_drained", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vec[v].n; k++) send(vec[v].w[k], vec[v].last && k == vec[v].n - 1);
      check_batch($sformatf("vec%0d", v), vec[v].cnt, vec[v].exp);
      tick();
      chk($sformatf("vec%0d_hold_valid", v), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_hold_slot0", v), 64'(bus.out_operands[W-1:0]), 64'(vec[v].exp[0]));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_taken", v), 64'(bus.out_valid), 64'd0);
    end
    // both banks fill under backpressure, then drain in order
    q.delete();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_data = W'(i);
      chk($sformatf("bp_in_ready%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_data = W'(17);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_stall_ready%0d", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("bp_stall_valid%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp_stall_slot0_%0d", c), 64'(bus.out_operands[W-1:0]), 64'd1);
      chk($sformatf("bp_stall_slot7_%0d", c), 64'(bus.out_operands[7*W +: W]), 64'd8);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(W'(17), 1'b0);
    send(W'(18), 1'b0);
    send(W'(19), 1'b0);
    send(W'(20), 1'b1);
    wait_q(3);
    chk("bp_batches", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      for (int j = 0; j < N; j++) begin
        chk($sformatf("bp_b0_s%0d", j), 64'(q[0].s[j]), 64'(j + 1));
        chk($sformatf("bp_b1_s%0d", j), 64'(q[1].s[j]), 64'(j + 9));
        chk($sformatf("bp_b2_s%0d", j), 64'(q[2].s[j]), j < 4 ? 64'(j + 17) : 64'd0);
      end
      chk("bp_b0_cnt", 64'(q[0].cnt), 64'd8);
      chk("bp_b1_cnt", 64'(q[1].cnt), 64'd8);
      chk("bp_b2_cnt", 64'(q[2].cnt), 64'd4);
    end
    // 64 words back to back with the consumer always ready
    q.delete();
    gaps = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_data = W'(32'h1000 + i);
      if (!bus.in_ready) gaps++;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_q(8);
    chk("b2b_gaps", 64'(gaps), 64'd0);
    chk("b2b_batches", 64'(q.size()), 64'd8);
    for (int b = 0; b < 8 && b < q.size(); b++) begin
      chk($sformatf("b2b_b%0d_cnt", b), 64'(q[b].cnt), 64'd8);
      for (int j = 0; j < N; j++)
        chk($sformatf("b2b_b%0d_s%0d", b, j), 64'(q[b].s[j]), 64'(32'h1000 + 8 * b + j));
    end
    // reset lands in the middle of a partial batch
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(W'(32'h55 + i), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_operands_zero", 64'(bus.out_operands == '0), 64'd1);
    tick();
    reset = 1'b0;
    #1 chk("mid_rst_release_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < N; i++) send(W'(32'h200 + i), 1'b0);
    e = '{48'h200, 48'h201, 48'h202, 48'h203, 48'h204, 48'h205, 48'h206, 48'h207};
    check_batch("after_rst", 4'd8, e);
    bus.out_ready = 1'b1;
    tick();
    chk("after_rst_taken", 64'(bus.out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_tree_operand_loader.md
Name: adder_tree_operand_loader

Overview:
Serial-to-parallel front end that feeds the adder-tree benchmarks. It accepts one ADDER_WIDTH-bit operand per cycle on a valid/ready stream and packs NUM_OPERANDS operands into a batch. Each batch is presented in parallel on a flat bus to the tree leaf inputs. Two ping-pong banks let filling continue while the previous batch waits for the tree side.

Parameters:
ADDER_WIDTH, 48, width of one operand word
NUM_OPERANDS, 8, operands per batch (tree leaf count); power of two, at least 2
CNT_W, 4, width of out_count; must satisfy 2**CNT_W > NUM_OPERANDS

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  loader can accept a word this cycle
in_data  input  ADDER_WIDTH  operand word
in_last  input  1  qualifies in_data as the final word of a short batch
out_valid  output  1  batch available
out_ready  input  1  downstream accepts batch
out_operands  output  NUM_OPERANDS*ADDER_WIDTH  slot i at bits [i*ADDER_WIDTH +: ADDER_WIDTH]; slot 0 is the first word accepted
out_count  output  CNT_W  number of real operands in the batch (1..NUM_OPERANDS)

Behaviour:
- Input accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Two banks, each with state EMPTY/FILLING/FULL, a fill index 0..NUM_OPERANDS-1 and a stored count. Pointers: wr_bank selects the bank being filled; rd_bank selects the bank being presented.
- in_ready = (bank[wr_bank] != FULL) && !reset. It is combinational from registered state only, with no dependence on in_valid or out_ready.
- Accept: write in_data to slot[fill index] and increment the index. The bank closes (goes FULL, count latched, wr_bank toggles) when:
  - the index reaches NUM_OPERANDS-1, or
  - in_last=1 is accepted. Slots above the last written slot read as zero. Pad is applied at close; stale data must never appear.
- An in_last word landing in the final slot behaves as a normal full close with count=NUM_OPERANDS.
- in_last is ignored when not accepted.
- out_valid = (bank[rd_bank] == FULL), registered. out_operands and out_count reflect bank[rd_bank] and are stable while out_valid && !out_ready.
- Latency: out_valid rises the cycle after the closing word is accepted, provided rd_bank points at that bank.
- Output transfer: bank[rd_bank] goes EMPTY, its fill index clears, and rd_bank toggles. If the other bank is FULL, out_valid stays high the next cycle with the new batch.
- Simultaneous accept into wr_bank and transfer from rd_bank in the same cycle: both take effect.
  - If a bank is freed this cycle, it is writable from the next cycle (in_ready is not combinationally forwarded from out_ready).
- Throughput: with out_ready held at 1, in_ready never deasserts, giving one word per cycle sustained.
- Both banks FULL: in_ready=0 until a transfer. No words are dropped or overwritten.
- Reset (async assert, any time including mid-batch):
  - both banks EMPTY, indices 0, wr_bank=rd_bank=0;
  - out_valid=0, out_count=0, out_operands=0, in_ready=0;
  - partial batches are discarded;
  - in_ready goes to 1 in the first cycle after deassertion.
- Arithmetic: the fill index is a modulo counter of width clog2(NUM_OPERANDS), cleared on close. Counts are unsigned with no wrap beyond NUM_OPERANDS.

Decomposition:
- Package adder_tree_pkg holds:
  - ADDER_WIDTH and NUM_OPERANDS defaults;
  - derived IDX_W = clog2(NUM_OPERANDS) and CNT_W;
  - bank_state_t enum {EMPTY, FILLING, FULL}.
- One sub-module, operand_bank: storage for NUM_OPERANDS words, fill index, state, count and zero-pad on close. The loader instantiates it twice and owns the ping-pong pointers and handshake logic.

Test Plan:
- Reset, then stream 8 words 1..8 with out_ready=1 → out_valid one cycle after word 8; out_operands slots 0..7 = 1..8; out_count=8; in_ready held at 1 throughout.
- Stream 3 words 0xA,0xB,0xC with in_last on 0xC → out_count=3; slots 0..2 = A,B,C; slots 3..7 = 0, even if the bank previously held nonzero data.
- out_ready=0, stream 20 words → in_ready drops after word 16; out_valid holds batch 1..8 stable. Raise out_ready → batches 1..8, then 9..16, then 17..20 with in_last, in order.
- Back-to-back: 64 words continuous, out_ready=1 → 8 batches, no in_ready gaps, consecutive out_valid cycles carry the correct words.
- Assert reset after 5 words of a batch, then send 8 new words → first batch out contains only the new words; out_count=8.
- Single word with in_last (0xFFFF_FFFF_FFFF) → out_count=1; slot 0 = all ones; other slots 0.
